// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS      = 2'd1,
    RESP_OK  = 2'd2,
    RESP_ERR = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin (RR=1) or data-first fixed priority (RR=0).
// Ports: req_i/req_d requests, take commits the pick into last_grant, gnt is the pick.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output gnt_t gnt
);

  gnt_t last_grant;

  always_comb begin
    gnt = GNT_I;
    if (req_i && req_d) begin
      if (RR) gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
      else    gnt = GNT_D;
    end else if (req_d) begin
      gnt = GNT_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= GNT_I;
    else if (take) last_grant <= gnt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction-fetch / data port arbiter in front of the unified block RAM.
// Ports: i_* read-only fetch master, d_* read/write data master,
// m_* stb/ack RAM slave. All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned M_ADR_W = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        i_adr,
  input  logic               i_stb,
  output logic [31:0]        i_dat,
  output logic               i_ack,
  output logic               i_err,
  input  logic [31:0]        d_adr,
  input  logic [31:0]        d_dat_i,
  input  logic               d_we,
  input  logic               d_stb,
  output logic [31:0]        d_dat_o,
  output logic               d_ack,
  output logic               d_err,
  output logic [M_ADR_W-1:0] m_adr,
  output logic [31:0]        m_dat_o,
  output logic               m_we,
  output logic               m_stb,
  input  logic [31:0]        m_dat_i,
  input  logic               m_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_n;
  gnt_t               owner, owner_n, gnt;
  logic               is_wr, is_wr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [M_ADR_W-1:0] m_adr_n;
  logic [31:0]        m_dat_n, i_dat_n, d_dat_n;
  logic               m_we_n, m_stb_n, i_ack_n, i_err_n, d_ack_n, d_err_n;
  logic               take;

  rr_arb2 #(.RR(RR)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (i_stb),
    .req_d (d_stb),
    .take  (take),
    .gnt   (gnt)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    is_wr_n = is_wr;
    cnt_n   = cnt;
    m_adr_n = m_adr;
    m_dat_n = m_dat_o;
    m_we_n  = m_we;
    m_stb_n = m_stb;
    i_dat_n = i_dat;
    d_dat_n = d_dat_o;
    i_ack_n = 1'b0;
    i_err_n = 1'b0;
    d_ack_n = 1'b0;
    d_err_n = 1'b0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        // m_ack still high here is the previous transfer's (or pre-reset) ack.
        if ((i_stb || d_stb) && !m_ack) begin
          take    = 1'b1;
          owner_n = gnt;
          state_n = BUS;
          m_stb_n = 1'b1;
          cnt_n   = '0;
          if (gnt == GNT_D) begin
            m_adr_n = M_ADR_W'(d_adr);
            m_dat_n = d_dat_i;
            m_we_n  = d_we;
            is_wr_n = d_we;
          end else begin
            m_adr_n = M_ADR_W'(i_adr);
            m_we_n  = 1'b0;
            is_wr_n = 1'b0;
          end
        end
      end
      BUS: begin
        cnt_n = cnt + CNT_W'(1);
        if (m_ack) begin
          m_stb_n = 1'b0;
          m_we_n  = 1'b0;
          state_n = RESP_OK;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          m_stb_n = 1'b0;
          state_n = RESP_ERR;
        end
      end
      RESP_OK: begin
        state_n = IDLE;
        if (owner == GNT_D) begin
          d_ack_n = 1'b1;
          if (!is_wr) d_dat_n = m_dat_i;
        end else begin
          i_ack_n = 1'b1;
          i_dat_n = m_dat_i;
        end
      end
      RESP_ERR: begin
        state_n = IDLE;
        if (owner == GNT_D) d_err_n = 1'b1;
        else                i_err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= GNT_I;
      is_wr   <= 1'b0;
      cnt     <= '0;
      m_adr   <= '0;
      m_dat_o <= '0;
      m_we    <= 1'b0;
      m_stb   <= 1'b0;
      i_dat   <= '0;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      d_dat_o <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      is_wr   <= is_wr_n;
      cnt     <= cnt_n;
      m_adr   <= m_adr_n;
      m_dat_o <= m_dat_n;
      m_we    <= m_we_n;
      m_stb   <= m_stb_n;
      i_dat   <= i_dat_n;
      i_ack   <= i_ack_n;
      i_err   <= i_err_n;
      d_dat_o <= d_dat_n;
      d_ack   <= d_ack_n;
      d_err   <= d_err_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural stb/ack RAM.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] i_adr, i_dat, d_adr, d_dat_i, d_dat_o, m_dat_o, m_dat_i;
  logic        i_stb, i_ack, i_err, d_we, d_stb, d_ack, d_err, m_we, m_stb, m_ack;
  logic [32:0] m_adr;

  mem_arbiter #(.RR(1'b1), .TIMEOUT(15), .M_ADR_W(33)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr(i_adr), .i_stb(i_stb), .i_dat(i_dat), .i_ack(i_ack), .i_err(i_err),
    .d_adr(d_adr), .d_dat_i(d_dat_i), .d_we(d_we), .d_stb(d_stb),
    .d_dat_o(d_dat_o), .d_ack(d_ack), .d_err(d_err),
    .m_adr(m_adr), .m_dat_o(m_dat_o), .m_we(m_we), .m_stb(m_stb),
    .m_dat_i(m_dat_i), .m_ack(m_ack)
  );

  // RAM model: ack one cycle after stb, access on stb&ack edge, data next cycle
  logic [31:0]  mem [0:255];
  logic [255:0] wr_valid  = '0;
  logic         ram_ack   = 1'b0;
  logic [31:0]  ram_rdata = '0;
  logic         stuck, hold_ack;
  int unsigned  writes = 0;

  function automatic logic [31:0] dflt(input logic [7:0] idx);
    case (idx)
      8'd4:    return 32'hDEADBEEF;
      8'd8:    return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  assign m_ack   = hold_ack | ram_ack;
  assign m_dat_i = ram_rdata;

  always @(posedge clk) begin
    ram_ack <= !stuck && m_stb && !ram_ack;
    if (m_stb && m_ack && !stuck) begin
      if (m_we) begin
        mem[m_adr[9:2]]      <= m_dat_o;
        wr_valid[m_adr[9:2]] <= 1'b1;
        writes               <= writes + 1;
      end else begin
        ram_rdata <= wr_valid[m_adr[9:2]] ? mem[m_adr[9:2]] : dflt(m_adr[9:2]);
      end
    end
  end

  // Fixed-priority instance with a trivial slave
  logic        fp_i_stb, fp_d_stb, fp_i_ack, fp_i_err, fp_d_ack, fp_d_err, fp_m_we, fp_m_stb;
  logic [31:0] fp_i_dat, fp_d_dat_o, fp_m_dat_o;
  logic [32:0] fp_m_adr;
  logic        fp_ack = 1'b0;
  always @(posedge clk) fp_ack <= fp_m_stb & !fp_ack;

  mem_arbiter #(.RR(1'b0), .TIMEOUT(15), .M_ADR_W(33)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_adr(32'h0), .i_stb(fp_i_stb), .i_dat(fp_i_dat), .i_ack(fp_i_ack), .i_err(fp_i_err),
    .d_adr(32'h4), .d_dat_i(32'h0), .d_we(1'b0), .d_stb(fp_d_stb),
    .d_dat_o(fp_d_dat_o), .d_ack(fp_d_ack), .d_err(fp_d_err),
    .m_adr(fp_m_adr), .m_dat_o(fp_m_dat_o), .m_we(fp_m_we), .m_stb(fp_m_stb),
    .m_dat_i(32'h0), .m_ack(fp_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port; // 0 = instruction, 1 = data
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] pulses;

  // Monitor: every response pulse pops the oldest expectation
  always @(negedge clk) begin
    pulses = {i_ack, i_err, d_ack, d_err};
    if (pulses != 4'b0) begin
      if ($countones(pulses) != 1) begin
        chk("single_pulse", pulses, 4'b0);
      end else if (sb.size() == 0) begin
        chk("unexpected_resp", pulses, 4'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_port", d_ack | d_err, mon_e.port);
        chk("resp_err", i_err | d_err, mon_e.err);
        if (mon_e.rd || mon_e.err)
          chk("resp_data", (d_ack | d_err) ? d_dat_o : i_dat, mon_e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit port, input bit err, input bit rd, input logic [31:0] data);
    exp_t e;
    e.port = port; e.err = err; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // One request on one port; reports latency, m_stb-high cycles and granted address
  task automatic xfer(input bit port, input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [31:0] exp, input bit err,
                      output int lat, output int stbc, output logic [32:0] adr_seen);
    bit done = 1'b0;
    lat = 0; stbc = 0; adr_seen = '1;
    push(port, err, !we, exp);
    if (port) begin d_adr = adr; d_we = we; d_dat_i = wdat; d_stb = 1'b1; end
    else begin i_adr = adr; i_stb = 1'b1; end
    while (!done && lat < 60) begin
      tick;
      lat++;
      if (m_stb) begin
        if (stbc == 0) adr_seen = m_adr;
        stbc++;
      end
      if (port ? (d_ack | d_err) : (i_ack | i_err)) done = 1'b1;
    end
    i_stb = 1'b0; d_stb = 1'b0; d_we = 1'b0;
    chk("xfer_done", done, 1'b1);
  endtask

  task automatic both_req(input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] iexp, input logic [31:0] dexp, input int first);
    int n = 0;
    int seen = 2;
    i_adr = ia; d_adr = da; d_we = 1'b0;
    if (first == 1) begin push(1, 0, 1, dexp); push(0, 0, 1, iexp); end
    else begin push(0, 0, 1, iexp); push(1, 0, 1, dexp); end
    i_stb = 1'b1; d_stb = 1'b1;
    while ((i_stb || d_stb) && n < 40) begin
      tick;
      n++;
      if (i_ack | i_err) begin if (seen == 2) seen = 0; i_stb = 1'b0; end
      if (d_ack | d_err) begin if (seen == 2) seen = 1; d_stb = 1'b0; end
    end
    chk("both_done", {i_stb, d_stb}, 2'b00);
    chk("first_grant", seen, first);
    i_stb = 1'b0; d_stb = 1'b0;
  endtask

  task automatic fp_round;
    int n = 0;
    int seen = 2;
    // data alone first so a round-robin picker would favour instruction next
    fp_d_stb = 1'b1;
    while (!fp_d_ack && n < 20) begin tick; n++; end
    fp_d_stb = 1'b0;
    chk("fp_solo_done", fp_d_ack, 1'b1);
    tick;
    n = 0;
    fp_i_stb = 1'b1; fp_d_stb = 1'b1;
    while ((fp_i_stb || fp_d_stb) && n < 40) begin
      tick;
      n++;
      if (fp_i_ack) begin if (seen == 2) seen = 0; fp_i_stb = 1'b0; end
      if (fp_d_ack) begin if (seen == 2) seen = 1; fp_d_stb = 1'b0; end
    end
    chk("fp_first_grant", seen, 1);
    fp_i_stb = 1'b0; fp_d_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stbc, n, acks, ack2;
    logic [32:0] adr_seen;
    logic [31:0] last_d;
    rst_n = 1'b0; stuck = 1'b0; hold_ack = 1'b0;
    i_adr = '0; i_stb = 1'b0; d_adr = '0; d_dat_i = '0; d_we = 1'b0; d_stb = 1'b0;
    fp_i_stb = 1'b0; fp_d_stb = 1'b0;
    tick; tick;
    chk("rst_m_stb", m_stb, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 4'b0);
    chk("rst_m_adr", m_adr, 33'h0);
    chk("rst_data", {m_dat_o, i_dat}, 64'h0);
    chk("rst_d_dat", d_dat_o, 32'h0);
    rst_n = 1'b1;
    tick;

    // Instruction read
    xfer(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, lat, stbc, adr_seen);
    chk("i_rd_latency", lat, 4);
    chk("i_rd_stb_cycles", stbc, 2);
    chk("i_rd_m_adr", adr_seen, 33'h0_0000_0010);
    tick;

    // Data write then read back
    n = writes;
    xfer(1, 1, 32'h40, 32'h12345678, 32'h0, 0, lat, stbc, adr_seen);
    chk("d_wr_latency", lat, 4);
    tick;
    chk("d_wr_count", writes - n, 1);
    xfer(1, 0, 32'h40, 32'h0, 32'h12345678, 0, lat, stbc, adr_seen);
    chk("d_rd_latency", lat, 4);
    tick;

    // Round-robin from reset: D first; after a lone D, I wins the tie
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    both_req(32'h10, 32'h40, 32'hDEADBEEF, 32'h12345678, 1);
    tick;
    xfer(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, lat, stbc, adr_seen);
    tick;
    both_req(32'h20, 32'h40, 32'hCAFEF00D, 32'h12345678, 0);
    last_d = 32'h12345678;
    tick;

    // Fixed priority: data wins every tie
    fp_round;
    tick;
    fp_round;
    tick;

    // Stuck slave: error after 15 BUS cycles, data output untouched
    stuck = 1'b1;
    xfer(1, 0, 32'h44, 32'h0, last_d, 1, lat, stbc, adr_seen);
    chk("to_latency", lat, 17);
    chk("to_stb_cycles", stbc, 15);
    tick;
    chk("to_err_pulse", {d_err, d_ack, m_stb}, 3'b000);
    stuck = 1'b0;
    tick;

    // Reset while in BUS with m_ack high
    i_adr = 32'h10; i_stb = 1'b1; n = 0;
    while (!(m_stb && m_ack) && n < 10) begin tick; n++; end
    chk("bus_ack_reached", m_stb & m_ack, 1'b1);
    hold_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m", {m_stb, m_we, m_adr}, 35'h0);
    chk("async_rst_dat", {m_dat_o, i_dat, d_dat_o}, 96'h0);
    chk("async_rst_pulse", {i_ack, d_ack, i_err, d_err}, 4'b0);
    tick;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin tick; if (m_stb) n++; end
    chk("no_grant_on_stale_ack", n, 0);
    hold_ack = 1'b0;
    push(0, 0, 1, 32'hDEADBEEF);
    lat = 0;
    while (!i_ack && lat < 20) begin tick; lat++; end
    i_stb = 1'b0;
    chk("post_rst_latency", lat, 4);
    tick;

    // Held stb after ack: a second identical read follows
    push(0, 0, 1, 32'hCAFEF00D);
    push(0, 0, 1, 32'hCAFEF00D);
    i_adr = 32'h20; i_stb = 1'b1;
    acks = 0; n = 0; ack2 = 0;
    while (acks < 2 && n < 30) begin
      tick;
      n++;
      if (i_ack) begin acks++; if (acks == 2) ack2 = n; end
    end
    i_stb = 1'b0;
    chk("held_ack_count", acks, 2);
    chk("held_second_ack_cycle", ack2, 8);
    tick; tick; tick;
    chk("held_no_extra", {i_ack, m_stb}, 2'b00);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
